// File: rtl/ysyx_22050133_lsu_if.sv
// Bundle of the LSU's handshake and bus signals.
//   upstream   : in_valid/in_ready plus the op fields from execute
//   downstream : out_valid/out_ready plus writeback data, rd, wen and fault
//   memory     : mem_req/mem_gnt request phase, mem_rvalid/mem_rdata/mem_err response
// The LSU connects through the slave modport; the pipeline/memory side
// through the master modport.
interface ysyx_22050133_lsu_if;
  logic        in_valid;
  logic        in_ready;
  logic        in_ren;
  logic        in_wen;
  logic [1:0]  in_size;
  logic        in_unsigned;
  logic [63:0] in_res;
  logic [63:0] in_wdata;
  logic [4:0]  in_rd;

  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic [4:0]  out_rd;
  logic        out_wen;
  logic        out_fault;

  logic        mem_req;
  logic        mem_gnt;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wmask;
  logic        mem_rvalid;
  logic [63:0] mem_rdata;
  logic        mem_err;

  modport slave (
    input  in_valid, in_ren, in_wen, in_size, in_unsigned, in_res, in_wdata, in_rd,
    output in_ready,
    output out_valid, out_data, out_rd, out_wen, out_fault,
    input  out_ready,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
    input  mem_gnt, mem_rvalid, mem_rdata, mem_err
  );

  modport master (
    output in_valid, in_ren, in_wen, in_size, in_unsigned, in_res, in_wdata, in_rd,
    input  in_ready,
    input  out_valid, out_data, out_rd, out_wen, out_fault,
    output out_ready,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
    output mem_gnt, mem_rvalid, mem_rdata, mem_err
  );
endinterface

// File: rtl/ysyx_22050133_lsu.sv
// Load/store unit: accepts one op at a time, runs at most one 64-bit bus
// transaction for it, and presents a single writeback/fault result.
//   clk  : system clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : upstream op, downstream result and memory bus (slave modport)
// TMO is the number of WAIT cycles without mem_rvalid before a bus timeout.
module ysyx_22050133_lsu #(
  parameter int unsigned TMO = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  ysyx_22050133_lsu_if.slave    bus
);
  localparam int CW = $clog2(TMO + 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;

  state_e      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic [63:0] data_q, data_d;
  logic [7:0]  wmask_q, wmask_d;
  logic [1:0]  size_q, size_d;
  logic [4:0]  rd_q, rd_d;
  logic        uns_q, uns_d;
  logic        st_q, st_d;
  logic        wen_q, wen_d;
  logic        flt_q, flt_d;

  logic        misal;
  logic [7:0]  bmask;
  logic [63:0] rsh;
  logic [63:0] ld_val;

  // Alignment check and byte-lane mask for the incoming op.
  always_comb begin
    misal = 1'b0;
    bmask = 8'h01;
    case (bus.in_size)
      2'd0: begin misal = 1'b0;               bmask = 8'h01; end
      2'd1: begin misal = bus.in_res[0];      bmask = 8'h03; end
      2'd2: begin misal = |bus.in_res[1:0];   bmask = 8'h0F; end
      default: begin misal = |bus.in_res[2:0]; bmask = 8'hFF; end
    endcase
  end

  // Move the addressed bytes of the returned beat down to bit 0, then extend.
  always_comb begin
    rsh    = bus.mem_rdata >> {addr_q[2:0], 3'b000};
    ld_val = rsh;
    case (size_q)
      2'd0: ld_val = uns_q ? {56'b0, rsh[7:0]}  : {{56{rsh[7]}}, rsh[7:0]};
      2'd1: ld_val = uns_q ? {48'b0, rsh[15:0]} : {{48{rsh[15]}}, rsh[15:0]};
      2'd2: ld_val = uns_q ? {32'b0, rsh[31:0]} : {{32{rsh[31]}}, rsh[31:0]};
      default: ld_val = rsh;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    data_d  = data_q;
    size_d  = size_q;
    rd_d    = rd_q;
    uns_d   = uns_q;
    st_d    = st_q;
    wen_d   = wen_q;
    flt_d   = flt_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          addr_d = bus.in_res;
          size_d = bus.in_size;
          uns_d  = bus.in_unsigned;
          rd_d   = bus.in_rd;
          st_d   = bus.in_wen;  // ren+wen together is a store
          if (!bus.in_ren && !bus.in_wen) begin
            state_d = DONE;
            data_d  = bus.in_res;
            wen_d   = 1'b1;
            flt_d   = 1'b0;
          end else if (misal) begin
            state_d = DONE;
            data_d  = bus.in_res;
            wen_d   = 1'b0;
            flt_d   = 1'b1;
          end else begin
            state_d = REQ;
            wdata_d = bus.in_wdata << {bus.in_res[2:0], 3'b000};
            wmask_d = bus.in_wen ? (bmask << bus.in_res[2:0]) : 8'h00;
          end
        end
      end
      REQ: begin
        if (bus.mem_gnt) begin
          state_d = WAIT;
          cnt_d   = '0;
        end
      end
      WAIT: begin
        // A response arriving on the timeout cycle still counts as a response.
        if (bus.mem_rvalid) begin
          state_d = DONE;
          if (bus.mem_err) begin
            data_d = addr_q;
            wen_d  = 1'b0;
            flt_d  = 1'b1;
          end else if (st_q) begin
            data_d = '0;
            wen_d  = 1'b0;
            flt_d  = 1'b0;
          end else begin
            data_d = ld_val;
            wen_d  = 1'b1;
            flt_d  = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(TMO - 1)) begin
            state_d = DONE;
            data_d  = addr_q;
            wen_d   = 1'b0;
            flt_d   = 1'b1;
          end
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
      data_q  <= '0;
      size_q  <= '0;
      rd_q    <= '0;
      uns_q   <= 1'b0;
      st_q    <= 1'b0;
      wen_q   <= 1'b0;
      flt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      data_q  <= data_d;
      size_q  <= size_d;
      rd_q    <= rd_d;
      uns_q   <= uns_d;
      st_q    <= st_d;
      wen_q   <= wen_d;
      flt_q   <= flt_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE) && rst;
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_data  = data_q;
  assign bus.out_rd    = rd_q;
  assign bus.out_wen   = wen_q;
  assign bus.out_fault = flt_q;

  // Write qualifiers are only driven while a request is on the bus.
  assign bus.mem_req   = (state_q == REQ);
  assign bus.mem_we    = (state_q == REQ) && st_q;
  assign bus.mem_addr  = {addr_q[63:3], 3'b000};
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_wmask = (state_q == REQ) ? wmask_q : 8'h00;
endmodule

// File: tb/tb_ysyx_22050133_lsu.sv
module tb_ysyx_22050133_lsu;
  logic clk;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  ysyx_22050133_lsu_if bus();

  ysyx_22050133_lsu #(.TMO(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic issue(input logic ren, input logic wen, input logic [1:0] sz, input logic uns,
                       input logic [63:0] res, input logic [63:0] wd, input logic [4:0] rdi);
    bus.in_valid = 1'b1; bus.in_ren = ren; bus.in_wen = wen; bus.in_size = sz;
    bus.in_unsigned = uns; bus.in_res = res; bus.in_wdata = wd; bus.in_rd = rdi;
    step();
    bus.in_valid = 1'b0;
  endtask

  // gd cycles of REQ before grant, then rd_dly WAIT cycles before the response.
  task automatic mem_txn(input int gd, input int rd_dly, input logic [63:0] rdata, input logic err);
    repeat (gd) step();
    bus.mem_gnt = 1'b1;
    step();
    bus.mem_gnt = 1'b0;
    repeat (rd_dly) step();
    bus.mem_rvalid = 1'b1; bus.mem_rdata = rdata; bus.mem_err = err;
    step();
    bus.mem_rvalid = 1'b0; bus.mem_err = 1'b0;
  endtask

  task automatic drain();
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    bus.in_valid = 0; bus.in_ren = 0; bus.in_wen = 0; bus.in_size = 0; bus.in_unsigned = 0;
    bus.in_res = 0; bus.in_wdata = 0; bus.in_rd = 0; bus.out_ready = 0;
    bus.mem_gnt = 0; bus.mem_rvalid = 0; bus.mem_rdata = 0; bus.mem_err = 0;

    // Reset state
    repeat (2) step();
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_mem_req", bus.mem_req, 0);
    chk("rst_mem_we", bus.mem_we, 0);
    chk("rst_wmask", bus.mem_wmask, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_wen", bus.out_wen, 0);
    chk("rst_out_fault", bus.out_fault, 0);
    rst = 1'b1;
    step();
    chk("post_rst_in_ready", bus.in_ready, 1);

    // ADD passthrough
    issue(0, 0, 2'd3, 0, 64'h1234, 64'h0, 5'd5);
    chk("add_valid", bus.out_valid, 1);
    chk("add_data", bus.out_data, 64'h1234);
    chk("add_wen", bus.out_wen, 1);
    chk("add_rd", bus.out_rd, 5);
    chk("add_fault", bus.out_fault, 0);
    chk("add_in_ready_busy", bus.in_ready, 0);
    drain();
    chk("add_drained", bus.out_valid, 0);
    chk("add_idle_ready", bus.in_ready, 1);

    // LB at 0x80000003
    issue(1, 0, 2'd0, 0, 64'h8000_0003, 64'h0, 5'd7);
    chk("lb_req", bus.mem_req, 1);
    chk("lb_addr", bus.mem_addr, 64'h8000_0000);
    chk("lb_we", bus.mem_we, 0);
    chk("lb_wmask", bus.mem_wmask, 0);
    mem_txn(1, 2, 64'h0000_0000_80FF_0000, 0);
    chk("lb_valid", bus.out_valid, 1);
    chk("lb_data", bus.out_data, 64'hFFFF_FFFF_FFFF_FF80);
    chk("lb_wen", bus.out_wen, 1);
    chk("lb_rd", bus.out_rd, 7);
    chk("lb_fault", bus.out_fault, 0);
    // Hold in DONE for three cycles; a stray response must be ignored.
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin bus.mem_rvalid = 1'b1; bus.mem_rdata = 64'h1; bus.mem_err = 1'b1; end
      step();
      bus.mem_rvalid = 1'b0; bus.mem_err = 1'b0;
      chk("hold_valid", bus.out_valid, 1);
      chk("hold_data", bus.out_data, 64'hFFFF_FFFF_FFFF_FF80);
      chk("hold_rd", bus.out_rd, 7);
      chk("hold_wen", bus.out_wen, 1);
      chk("hold_fault", bus.out_fault, 0);
    end
    drain();

    // LBU same address
    issue(1, 0, 2'd0, 1, 64'h8000_0003, 64'h0, 5'd8);
    mem_txn(0, 0, 64'h0000_0000_80FF_0000, 0);
    chk("lbu_data", bus.out_data, 64'h80);
    drain();

    // LH signed at offset 2, LW signed / unsigned at offset 4
    issue(1, 0, 2'd1, 0, 64'h8000_0012, 64'h0, 5'd10);
    mem_txn(0, 1, 64'h0000_0000_8765_0000, 0);
    chk("lh_data", bus.out_data, 64'hFFFF_FFFF_FFFF_8765);
    drain();
    issue(1, 0, 2'd2, 0, 64'h8000_0014, 64'h0, 5'd11);
    mem_txn(0, 0, 64'h8000_0001_0000_0000, 0);
    chk("lw_data", bus.out_data, 64'hFFFF_FFFF_8000_0001);
    drain();
    issue(1, 0, 2'd2, 1, 64'h8000_0014, 64'h0, 5'd11);
    mem_txn(0, 0, 64'h8000_0001_0000_0000, 0);
    chk("lwu_data", bus.out_data, 64'h0000_0000_8000_0001);
    drain();

    // SH at 0x80000006
    issue(0, 1, 2'd1, 0, 64'h8000_0006, 64'hABCD, 5'd12);
    chk("sh_req", bus.mem_req, 1);
    chk("sh_addr", bus.mem_addr, 64'h8000_0000);
    chk("sh_wdata", bus.mem_wdata, 64'hABCD_0000_0000_0000);
    chk("sh_wmask", bus.mem_wmask, 8'hC0);
    chk("sh_we", bus.mem_we, 1);
    mem_txn(0, 0, 64'hDEAD, 0);
    chk("sh_valid", bus.out_valid, 1);
    chk("sh_wen", bus.out_wen, 0);
    chk("sh_data", bus.out_data, 0);
    chk("sh_rd", bus.out_rd, 12);
    drain();

    // SB with ren+wen both set at offset 7, SD full width
    issue(1, 1, 2'd0, 0, 64'h8000_000F, 64'h5A, 5'd13);
    chk("sb_we", bus.mem_we, 1);
    chk("sb_addr", bus.mem_addr, 64'h8000_0008);
    chk("sb_wmask", bus.mem_wmask, 8'h80);
    chk("sb_wdata", bus.mem_wdata, 64'h5A00_0000_0000_0000);
    mem_txn(0, 0, 64'h0, 0);
    chk("sb_wen", bus.out_wen, 0);
    drain();
    issue(0, 1, 2'd3, 0, 64'h8000_0018, 64'h0102_0304_0506_0708, 5'd14);
    chk("sd_wmask", bus.mem_wmask, 8'hFF);
    chk("sd_wdata", bus.mem_wdata, 64'h0102_0304_0506_0708);
    mem_txn(0, 0, 64'h0, 0);
    drain();

    // LW misaligned: immediate fault, no bus request
    issue(1, 0, 2'd2, 0, 64'h8000_0002, 64'h0, 5'd15);
    chk("mis_req", bus.mem_req, 0);
    chk("mis_valid", bus.out_valid, 1);
    chk("mis_fault", bus.out_fault, 1);
    chk("mis_data", bus.out_data, 64'h8000_0002);
    chk("mis_wen", bus.out_wen, 0);
    chk("mis_rd", bus.out_rd, 15);
    drain();

    // Timeout: TMO=4, fault exactly 4 cycles after grant
    issue(1, 0, 2'd3, 0, 64'h8000_0008, 64'h0, 5'd9);
    bus.mem_gnt = 1'b1;
    step();
    bus.mem_gnt = 1'b0;
    repeat (3) step();
    chk("tmo_not_yet", bus.out_valid, 0);
    step();
    chk("tmo_valid", bus.out_valid, 1);
    chk("tmo_fault", bus.out_fault, 1);
    chk("tmo_data", bus.out_data, 64'h8000_0008);
    chk("tmo_wen", bus.out_wen, 0);
    chk("tmo_rd", bus.out_rd, 9);
    drain();

    // Response on the timeout cycle wins
    issue(1, 0, 2'd3, 0, 64'h8000_0008, 64'h0, 5'd9);
    mem_txn(0, 3, 64'h1122_3344_5566_7788, 0);
    chk("race_fault", bus.out_fault, 0);
    chk("race_data", bus.out_data, 64'h1122_3344_5566_7788);
    chk("race_wen", bus.out_wen, 1);
    drain();

    // Bus error with rvalid
    issue(1, 0, 2'd2, 1, 64'h8000_0010, 64'h0, 5'd16);
    mem_txn(0, 1, 64'hFFFF, 1);
    chk("err_fault", bus.out_fault, 1);
    chk("err_data", bus.out_data, 64'h8000_0010);
    chk("err_wen", bus.out_wen, 0);
    chk("err_rd", bus.out_rd, 16);
    drain();

    // Reset in WAIT abandons the transaction
    issue(1, 0, 2'd3, 0, 64'h8000_0020, 64'h0, 5'd17);
    bus.mem_gnt = 1'b1;
    step();
    bus.mem_gnt = 1'b0;
    rst = 1'b0;
    #1;
    chk("mrst_valid", bus.out_valid, 0);
    chk("mrst_in_ready", bus.in_ready, 0);
    chk("mrst_out_wen", bus.out_wen, 0);
    step();
    rst = 1'b1;
    step();
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 64'h77;
    step();
    bus.mem_rvalid = 1'b0;
    chk("mrst_no_valid", bus.out_valid, 0);
    chk("mrst_ready", bus.in_ready, 1);
    step();
    chk("mrst_no_valid2", bus.out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ysyx_22050133_lsu.md
YSYX_22050133_LSU -- requirements
Module: ysyx_22050133_lsu

Interface
REQ-001 SHALL have parameter TMO, default 255, meaning the number of WAIT-state cycles without mem_rvalid before a bus timeout fault.
REQ-002 SHALL have port clk  in  1  system clock; all state changes on rising edge.
REQ-003 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have upstream ports in_valid in 1; in_ready out 1; in_ren in 1; in_wen in 1; in_size in 2 (0=B, 1=H, 2=W, 3=D); in_unsigned in 1; in_res in 64 (execute-stage result: the address for memory ops, the writeback value otherwise); in_wdata in 64 (store data, from rs2); in_rd in 5.
REQ-005 SHALL have downstream ports out_valid out 1; out_ready in 1; out_data out 64; out_rd out 5; out_wen out 1 (register writeback enable); out_fault out 1.
REQ-006 SHALL have memory ports mem_req out 1; mem_gnt in 1; mem_we out 1; mem_addr out 64 (always 8-byte aligned); mem_wdata out 64; mem_wmask out 8; mem_rvalid in 1; mem_rdata in 64; mem_err in 1.

Function
REQ-007 SHALL implement states IDLE, REQ, WAIT, DONE; in_ready=1 only in IDLE; out_valid=1 only in DONE; mem_req=1 only in REQ.
REQ-008 SHALL latch all in_* fields on accept (in_valid&&in_ready); in_ren&&in_wen both set SHALL be treated as a store.
REQ-009 Non-memory op (in_ren=0, in_wen=0): IDLE->DONE; out_data=in_res, out_wen=1, out_fault=0; out_valid one cycle after accept.
REQ-010 Misaligned memory op (in_res not a multiple of 1<<in_size): IDLE->DONE; no bus transaction; out_fault=1, out_data=in_res, out_wen=0.
REQ-011 Aligned memory op: IDLE->REQ; mem_addr={in_res[63:3],3'b0}, mem_we=store, held stable until mem_gnt; REQ->WAIT on mem_gnt.
REQ-012 Store lanes: mem_wdata=in_wdata shifted left by 8*in_res[2:0]; mem_wmask=((1<<(1<<in_size))-1)<<in_res[2:0]; loads drive mem_wmask=0.
REQ-013 mem_rvalid SHALL be sampled only in WAIT; WAIT->DONE on mem_rvalid; mem_rvalid and mem_err in any other state SHALL be ignored.
REQ-014 Load result: bytes = mem_rdata>>(8*addr[2:0]) truncated to size, sign-extended to 64 bits unless in_unsigned (zero-extended); in_unsigned with size D is a no-op.
REQ-015 Load completion: out_wen=1, out_fault=0, out_data=extended value; store completion: out_wen=0, out_data=0.
REQ-016 mem_err with mem_rvalid SHALL yield out_fault=1, out_wen=0, out_data=faulting address.
REQ-017 A 0..TMO counter SHALL clear on REQ->WAIT and increment each WAIT cycle without mem_rvalid; on reaching TMO, WAIT->DONE with fault per REQ-016; mem_rvalid in the same cycle as the counter reaching TMO SHALL win (normal completion).
REQ-018 out_data, out_rd, out_wen and out_fault SHALL be held stable while out_valid&&!out_ready; DONE->IDLE on out_ready.
REQ-019 Minimum issue interval is 2 cycles; no op SHALL be accepted in the cycle DONE exits.
REQ-020 out_rd SHALL equal the latched in_rd for every completion, including faults.

Reset
REQ-021 On rst=0, state SHALL go to IDLE immediately; mem_req, out_valid, out_wen, out_fault, mem_we SHALL be 0; mem_wmask=0; out_data=0; timeout counter=0; in_ready=0 while rst=0, 1 from the first cycle after release.
REQ-022 Reset during REQ or WAIT SHALL abandon the transaction; a later mem_rvalid SHALL not produce out_valid.

Verification
REQ-023 ADD passthrough: in_res=0x1234, rd=5, no ren/wen -> next cycle out_valid, out_data=0x1234, out_wen=1, out_rd=5.
REQ-024 LB at 0x80000003, mem_rdata=0x00000000_80FF0000, gnt after 2 cycles, rvalid 3 cycles later -> mem_addr=0x80000000, out_data=0xFFFFFFFFFFFFFF80; LBU -> 0x80.
REQ-025 SH at 0x80000006, in_wdata=0xABCD -> mem_wdata[63:48]=0xABCD, mem_wmask=0xC0, mem_we=1; completion out_wen=0.
REQ-026 LW at 0x80000002 -> out_fault=1, out_data=0x80000002, mem_req never asserted.
REQ-027 TMO=4, no mem_rvalid -> out_fault=1 exactly 4 cycles after grant; separately mem_err with rvalid -> out_fault=1.
REQ-028 rst low in WAIT, then release and pulse mem_rvalid -> no out_valid; out_ready held 0 three cycles in DONE -> outputs unchanged.
